// File: rtl/im_fetch_if.sv
// Requester-side fetch channel: request handshake plus single-cycle response.
interface im_fetch_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/im_fetch_arbiter.sv
// Two-requester round-robin arbiter that assembles 32-bit big-endian words
// from a byte-wide, combinationally read instruction memory.
module im_fetch_arbiter #(
  parameter int unsigned MEM_SIZE = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  im_fetch_if.slave                   req0,
  im_fetch_if.slave                   req1,
  output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
  input  logic [7:0]                  mem_rdata,
  output logic                        busy
);
  localparam int unsigned AW = $clog2(MEM_SIZE);
  localparam logic [31:0] LAST_WORD = 32'(MEM_SIZE - 4);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_e;

  state_e          state_q, state_d;
  logic [1:0]      beat_q, beat_d;
  logic [31:0]     data_q, data_d;
  logic            err_q, err_d;
  logic            gnt_q, gnt_d;
  logic            last_grant_q, last_grant_d;
  logic [AW-1:0]   base_q, base_d;

  logic            any_valid;
  logic            grant_sel;
  logic [31:0]     sel_addr;
  logic            addr_bad;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    any_valid = req0.req_valid | req1.req_valid;
    if (req0.req_valid && req1.req_valid) grant_sel = ~last_grant_q;
    else                                  grant_sel = req1.req_valid;
    sel_addr = grant_sel ? req1.req_addr : req0.req_addr;
    addr_bad = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      base_q       <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      data_q       <= data_d;
      err_q        <= err_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      base_q       <= base_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    data_d       = data_q;
    err_d        = err_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    base_d       = base_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          gnt_d        = grant_sel;
          last_grant_d = grant_sel;
          beat_d       = '0;
          data_d       = '0;
          err_d        = addr_bad;
          base_d       = sel_addr[AW-1:0];
          state_d      = addr_bad ? RESP : READ;
        end
      end
      READ: begin
        unique case (beat_q)
          2'd0: data_d[31:24] = mem_rdata;
          2'd1: data_d[23:16] = mem_rdata;
          2'd2: data_d[15:8]  = mem_rdata;
          2'd3: data_d[7:0]   = mem_rdata;
        endcase
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by reset so nothing is offered while the block is held.
  always_comb begin
    req0.req_ready = 1'b0;
    req1.req_ready = 1'b0;
    req0.rsp_valid = 1'b0;
    req0.rsp_data  = '0;
    req0.rsp_err   = 1'b0;
    req1.rsp_valid = 1'b0;
    req1.rsp_data  = '0;
    req1.rsp_err   = 1'b0;
    mem_addr       = '0;
    busy           = 1'b0;
    unique case (state_q)
      IDLE: begin
        req0.req_ready = rst & req0.req_valid & ~grant_sel;
        req1.req_ready = rst & req1.req_valid &  grant_sel;
      end
      READ: begin
        busy     = 1'b1;
        mem_addr = base_q + AW'(beat_q);
      end
      RESP: begin
        busy = 1'b1;
        if (gnt_q) begin
          req1.rsp_valid = 1'b1;
          req1.rsp_data  = data_q;
          req1.rsp_err   = err_q;
        end else begin
          req0.rsp_valid = 1'b1;
          req0.rsp_data  = data_q;
          req0.rsp_err   = err_q;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_im_fetch_arbiter.sv
// Directed bench for im_fetch_arbiter: vector table plus tie, late-request and reset-abort sequences.
module tb_im_fetch_arbiter;
  localparam int unsigned MEM_SIZE = 128;
  localparam int unsigned AW = $clog2(MEM_SIZE);

  logic          clk;
  logic          rst;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          busy;
  logic [7:0]    mem [MEM_SIZE];

  im_fetch_if r0 ();
  im_fetch_if r1 ();

  im_fetch_arbiter #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (r0.slave),
    .req1      (r1.slave),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_req(input logic sel, input logic v, input logic [31:0] a);
    if (sel) begin r1.req_valid = v; r1.req_addr = a; end
    else     begin r0.req_valid = v; r0.req_addr = a; end
  endtask

  function automatic logic get_ready(input logic sel);
    return sel ? r1.req_ready : r0.req_ready;
  endfunction

  function automatic logic get_rv(input logic sel);
    return sel ? r1.rsp_valid : r0.rsp_valid;
  endfunction

  // Both ports must show zero data/err while their response strobe is low.
  function automatic logic idle_zero();
    return ((r0.rsp_valid || (r0.rsp_data == 0 && !r0.rsp_err)) &&
            (r1.rsp_valid || (r1.rsp_data == 0 && !r1.rsp_err)));
  endfunction

  task automatic txn(input logic sel, input logic [31:0] addr, input logic exp_err,
                     input logic [31:0] exp_data, input string name);
    int lat = 0;
    int rsp_cnt = 0;
    logic got_ready = 1'b0;
    logic other_seen = 1'b0;
    logic addr_ok = 1'b1;
    logic zero_ok = 1'b1;
    logic busy1 = 1'b0;
    logic [31:0] data = '0;
    logic err = 1'b0;
    logic [AW-1:0] ea;
    @(negedge clk);
    set_req(sel, 1'b1, addr);
    #1;
    for (int i = 0; i < 20; i++) begin
      if (get_ready(sel)) begin got_ready = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk({name, " ready"}, 32'(got_ready), 32'd1);
    @(negedge clk);
    set_req(sel, 1'b0, 32'hDEAD_BEEF);
    for (int n = 1; n <= 8; n++) begin
      #1;
      if (n == 1) busy1 = busy;
      ea = addr[AW-1:0] + AW'(n - 1);
      if (!exp_err && n <= 4) begin
        if (mem_addr != ea) addr_ok = 1'b0;
      end else if (mem_addr != '0) addr_ok = 1'b0;
      if (get_rv(sel)) begin
        rsp_cnt++;
        if (lat == 0) begin
          lat  = n;
          data = sel ? r1.rsp_data : r0.rsp_data;
          err  = sel ? r1.rsp_err : r0.rsp_err;
        end
      end
      if (get_rv(!sel)) other_seen = 1'b1;
      if (!idle_zero()) zero_ok = 1'b0;
      @(negedge clk);
    end
    chk({name, " latency"}, 32'(lat), exp_err ? 32'd1 : 32'd5);
    chk({name, " rsp_count"}, 32'(rsp_cnt), 32'd1);
    chk({name, " data"}, data, exp_data);
    chk({name, " err"}, 32'(err), 32'(exp_err));
    chk({name, " other_port_quiet"}, 32'(other_seen), 32'd0);
    chk({name, " mem_addr_seq"}, 32'(addr_ok), 32'd1);
    chk({name, " zero_when_idle"}, 32'(zero_ok), 32'd1);
    chk({name, " busy"}, 32'(busy1), 32'd1);
  endtask

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic        err;
    logic [31:0] data;
    string       name;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int g_cnt, r_cnt, hs1, rs0, rs1;
    logic [31:0] d0, d1;
    logic both_ready, ready_early, rsp_seen, both_rsp;
    logic [1:0] grants [4];
    logic [1:0] rsps [4];
    logic rsp_data_ok;

    for (int unsigned i = 0; i < MEM_SIZE; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[0] = 8'h8C; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h04;

    vecs[0] = '{1'b0, 32'h0000_0000, 1'b0, 32'h8C01_0004, "r0_addr0"};
    vecs[1] = '{1'b1, 32'h0000_007C, 1'b0, 32'hD9D8_DBDA, "r1_last_word"};
    vecs[2] = '{1'b1, 32'h0000_0080, 1'b1, 32'h0,         "r1_past_end"};
    vecs[3] = '{1'b1, 32'h0000_0006, 1'b1, 32'h0,         "r1_misaligned"};
    vecs[4] = '{1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0,         "r0_alias_top"};
    vecs[5] = '{1'b0, 32'h0000_0010, 1'b0, 32'hB5B4_B7B6, "r0_addr10"};
    vecs[6] = '{1'b1, 32'h0000_007D, 1'b1, 32'h0,         "r1_misaligned_top"};
    vecs[7] = '{1'b1, 32'h0000_0020, 1'b0, 32'h8584_8786, "r1_addr20"};
    vecs[8] = '{1'b0, 32'h0000_0100, 1'b1, 32'h0,         "r0_bit8_set"};

    r0.req_valid = 1'b0; r0.req_addr = '0;
    r1.req_valid = 1'b0; r1.req_addr = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    r0.req_valid = 1'b1;
    r1.req_valid = 1'b1;
    #1;
    chk("reset ready0", 32'(r0.req_ready), 32'd0);
    chk("reset ready1", 32'(r1.req_ready), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset rsp", 32'({r0.rsp_valid, r1.rsp_valid}), 32'd0);
    @(negedge clk);
    r0.req_valid = 1'b0;
    r1.req_valid = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 9; i++)
      txn(vecs[i].sel, vecs[i].addr, vecs[i].err, vecs[i].data, vecs[i].name);

    // Continuous tie after reset: grants alternate starting with requester 0.
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    r0.req_valid = 1'b1; r0.req_addr = 32'h0;
    r1.req_valid = 1'b1; r1.req_addr = 32'h10;
    g_cnt = 0; r_cnt = 0; both_ready = 1'b0; both_rsp = 1'b0; rsp_data_ok = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (r0.req_ready && r1.req_ready) both_ready = 1'b1;
      if (r0.rsp_valid && r1.rsp_valid) both_rsp = 1'b1;
      if (g_cnt < 4 && (r0.req_ready || r1.req_ready)) begin
        grants[g_cnt] = r1.req_ready ? 2'd1 : 2'd0; g_cnt++;
      end
      if (r_cnt < 4 && (r0.rsp_valid || r1.rsp_valid)) begin
        rsps[r_cnt] = r1.rsp_valid ? 2'd1 : 2'd0; r_cnt++;
        if (r0.rsp_valid && r0.rsp_data != 32'h8C01_0004) rsp_data_ok = 1'b0;
        if (r1.rsp_valid && r1.rsp_data != 32'hB5B4_B7B6) rsp_data_ok = 1'b0;
      end
      @(negedge clk);
    end
    r0.req_valid = 1'b0; r1.req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("tie grant_count", 32'(g_cnt), 32'd4);
    chk("tie rsp_count", 32'(r_cnt), 32'd4);
    if (g_cnt == 4 && r_cnt == 4)
      chk("tie order", {grants[0], grants[1], grants[2], grants[3], rsps[0], rsps[1], rsps[2], rsps[3]},
          {2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1});
    chk("tie single_ready", 32'(both_ready), 32'd0);
    chk("tie single_rsp", 32'(both_rsp), 32'd0);
    chk("tie rsp_data", 32'(rsp_data_ok), 32'd1);

    // Requester 1 arrives during requester 0's READ and changes its address before ready.
    @(negedge clk);
    r0.req_valid = 1'b1; r0.req_addr = 32'h20;
    #1;
    chk("late r0 ready", 32'(r0.req_ready), 32'd1);
    hs1 = 0; rs0 = 0; rs1 = 0; d0 = '0; d1 = '0; ready_early = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      r0.req_valid = 1'b0;
      if (hs1 != 0) r1.req_valid = 1'b0;
      else if (n == 1) begin r1.req_valid = 1'b1; r1.req_addr = 32'h7C; end
      else if (n == 2) r1.req_addr = 32'h06;
      else if (n == 3) r1.req_addr = 32'h10;
      #1;
      if (n <= 5 && r1.req_ready) ready_early = 1'b1;
      if (hs1 == 0 && r1.req_ready) hs1 = n;
      if (rs0 == 0 && r0.rsp_valid) begin rs0 = n; d0 = r0.rsp_data; end
      if (rs1 == 0 && r1.rsp_valid) begin rs1 = n; d1 = {r1.rsp_data[31:1], r1.rsp_data[0] | r1.rsp_err}; end
    end
    chk("late r1 not_ready_while_busy", 32'(ready_early), 32'd0);
    chk("late r0 rsp_cycle", 32'(rs0), 32'd5);
    chk("late r0 data", d0, 32'h8584_8786);
    chk("late r1 hs_cycle", 32'(hs1), 32'd6);
    chk("late r1 rsp_cycle", 32'(rs1), 32'd11);
    chk("late r1 data", d1, 32'hB5B4_B7B6);

    // Reset pulse during beat 2 aborts the transaction without any response.
    @(negedge clk);
    r0.req_valid = 1'b1; r0.req_addr = 32'h0;
    #1;
    chk("abort r0 ready", 32'(r0.req_ready), 32'd1);
    @(negedge clk); r0.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("abort beat2 mem_addr", 32'(mem_addr), 32'd2);
    rst = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort mem_addr", 32'(mem_addr), 32'd0);
    rsp_seen = r0.rsp_valid | r1.rsp_valid;
    r0.req_valid = 1'b1; r0.req_addr = 32'h10;
    r1.req_valid = 1'b1; r1.req_addr = 32'h20;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (r0.rsp_valid || r1.rsp_valid || r0.req_ready || r1.req_ready) rsp_seen = 1'b1;
    end
    chk("abort no_rsp_in_reset", 32'(rsp_seen), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort tie grant", 32'({r0.req_ready, r1.req_ready}), 32'b10);
    hs1 = 0; rs0 = 0; rs1 = 0; d0 = '0; d1 = '0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      r0.req_valid = 1'b0;
      if (hs1 != 0) r1.req_valid = 1'b0;
      #1;
      if (hs1 == 0 && r1.req_ready) hs1 = n;
      if (rs0 == 0 && r0.rsp_valid) begin rs0 = n; d0 = r0.rsp_data; end
      if (rs1 == 0 && r1.rsp_valid) begin rs1 = n; d1 = r1.rsp_data; end
    end
    chk("abort r0 rsp_cycle", 32'(rs0), 32'd5);
    chk("abort r0 data", d0, 32'hB5B4_B7B6);
    chk("abort r1 rsp_cycle", 32'(rs1), 32'd11);
    chk("abort r1 data", d1, 32'h8584_8786);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/im_fetch_arbiter.md
IM_FETCH_ARBITER -- requirements
Module: im_fetch_arbiter

Interface
REQ-001 Parameter MEM_SIZE, default 128, SHALL be the instruction memory size in bytes; MEM_SIZE is a power of two and at least 4.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 req0_valid  input  1  SHALL be the requester-0 (CPU fetch) read request.
REQ-005 req0_addr  input  32  SHALL be the requester-0 byte address.
REQ-006 req0_ready  output  1  SHALL be the requester-0 accept strobe.
REQ-007 rsp0_valid / rsp0_data / rsp0_err  output  1/32/1  SHALL be the requester-0 response strobe, instruction word and error flag.
REQ-008 req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data, rsp1_err SHALL be identical ports for requester 1 (debug/trace reader).
REQ-009 mem_addr  output  log2(MEM_SIZE)  SHALL be the byte address driven to the byte-wide instruction memory.
REQ-010 mem_rdata  input  8  SHALL be the memory byte, combinationally valid in the same cycle as mem_addr.
REQ-011 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-012 FSM states SHALL be IDLE, READ, RESP.
REQ-013 Handshake: in IDLE, reqN_ready SHALL be asserted combinationally, for exactly the granted requester only, when that requester's valid is high; the transfer occurs on the edge where valid and ready are both high.
REQ-014 The address SHALL be sampled only at the handshake; reqN_valid and reqN_addr SHALL remain stable until ready, and any later change SHALL be ignored.
REQ-015 Arbitration: round-robin with a 1-bit last_grant register. If only one requester is valid, it is granted. If both are valid, the requester other than last_grant is granted. last_grant SHALL update at each handshake.
REQ-016 Error check at handshake: the request is rejected if addr[1:0] != 0 or addr > MEM_SIZE-4 (full 32-bit compare).
REQ-016a A rejected request SHALL go IDLE->RESP with err=1 and data=0; the response appears one cycle after the handshake.
REQ-017 A valid request SHALL go IDLE->READ, with beat counter 0..3 and mem_addr = base+beat.
REQ-017a The READ beat byte-to-lane mapping SHALL be big-endian: beat0->[31:24], beat1->[23:16], beat2->[15:8], beat3->[7:0].
REQ-017b mem_rdata SHALL be captured at the end of each beat, and READ->RESP SHALL occur after beat 3.
REQ-018 RESP SHALL last exactly one cycle. In it, rspN_valid=1 only for the granted requester, with the assembled data and err=0 (or err=1 from REQ-016). There is no backpressure. The next state is IDLE.
REQ-019 Latency: handshake at edge T -> rsp_valid high in cycle T+5 for a good read and T+1 for an error; the next handshake is possible at the earliest one cycle after RESP.
REQ-020 rspN_data and rspN_err SHALL be 0 whenever rspN_valid is 0.
REQ-021 mem_addr SHALL be 0 outside READ.
REQ-022 Addresses SHALL wrap nowhere: base+3 <= MEM_SIZE-1 is guaranteed by REQ-016.
REQ-023 A request arriving during READ/RESP SHALL see ready=0 and wait; no request may be lost or duplicated.

Reset
REQ-024 While rst=0, the state SHALL be IDLE, the beat counter 0, the data register 0 and last_grant=1 (so requester 0 wins the first tie).
REQ-025 While rst=0, all ready/rsp/busy outputs and mem_addr SHALL be 0.
REQ-026 Reset asserted mid-READ or mid-RESP SHALL abort the transaction immediately with no response issued; operation resumes from IDLE on the first edge after release.

Verification
REQ-027 Memory bytes 0x00..0x03 = 8C,01,00,04; req0 addr 0 -> req0_ready pulse at T, then mem_addr 0,1,2,3 in T+1..T+4; rsp0_valid at T+5 with data 0x8C010004, err=0.
REQ-028 req1 addr 0x7C (MEM_SIZE=128) -> good read of the last word; req1 addr 0x80 and addr 0x06 -> rsp1_valid at T+1 with err=1, data=0, and mem_addr stays 0.
REQ-029 req0 and req1 both held valid continuously after reset -> grant order 0,1,0,1; each response goes only to its own port.
REQ-030 req1 raised during req0's READ with its address changed twice before ready -> req1 is served after req0's RESP using the address present at its handshake.
REQ-031 rst pulsed low during beat 2 -> no rsp_valid on any port; busy=0 and mem_addr=0 immediately; the next request completes normally, with requester 0 winning a tie.
REQ-032 req0 addr 0xFFFF_FFFC -> err=1 (no 7-bit truncation alias to 0x7C).
